// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared edge- or center-aligned counter, per-channel
// duty compare, and a double-buffered (pending/active) configuration set.
module pwm_multi #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic                      mode_i,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic                      cyc_o,
  output logic                      pend_o
);

  typedef enum logic {DirUp, DirDown} dir_e;

  dir_e                      r_dir, w_dir_nxt;
  logic [WIDTH-1:0]          r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]          r_act_period, w_act_period_nxt;
  logic [CHANNELS*WIDTH-1:0] r_act_duty, w_act_duty_nxt;
  logic                      r_act_mode, w_act_mode_nxt;
  logic [WIDTH-1:0]          r_pend_period, w_pend_period_nxt;
  logic [CHANNELS*WIDTH-1:0] r_pend_duty, w_pend_duty_nxt;
  logic                      r_pend_mode, w_pend_mode_nxt;
  logic                      r_pend, w_pend_nxt;
  logic [CHANNELS-1:0]       r_pwm, w_pwm_nxt;
  logic                      r_cyc, w_cyc_nxt;
  logic                      w_wrap;
  logic                      w_apply;

  always_comb begin
    w_wrap            = 1'b0;
    w_apply           = 1'b0;
    w_cnt_nxt         = r_cnt;
    w_dir_nxt         = r_dir;
    w_act_period_nxt  = r_act_period;
    w_act_duty_nxt    = r_act_duty;
    w_act_mode_nxt    = r_act_mode;
    w_pend_period_nxt = r_pend_period;
    w_pend_duty_nxt   = r_pend_duty;
    w_pend_mode_nxt   = r_pend_mode;
    w_pend_nxt        = r_pend;
    w_pwm_nxt         = '0;
    w_cyc_nxt         = 1'b0;

    // Periods of 0 or 1 never reach the down phase in center mode, so they wrap at the top.
    if (r_act_mode) begin
      w_wrap = (r_dir == DirDown && r_cnt == WIDTH'(1)) ||
               (r_cnt == r_act_period && r_act_period <= WIDTH'(1));
    end else begin
      w_wrap = (r_cnt == r_act_period);
    end

    if (!en) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DirUp;
    end else if (w_wrap) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DirUp;
      w_cyc_nxt = 1'b1;
    end else if (!r_act_mode) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end else if (r_dir == DirUp) begin
      if (r_cnt == r_act_period) begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
        w_dir_nxt = DirDown;
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt - WIDTH'(1);
    end

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_pwm_nxt[k] = en && (r_cnt < r_act_duty[k*WIDTH +: WIDTH]);
    end

    if (load) begin
      w_pend_period_nxt = period_i;
      w_pend_duty_nxt   = duty_i;
      w_pend_mode_nxt   = mode_i;
      w_pend_nxt        = 1'b1;
    end

    // A load coinciding with an apply point bypasses the pending registers.
    w_apply = (!en || w_wrap) && (r_pend || load);
    if (w_apply) begin
      w_act_period_nxt = load ? period_i : r_pend_period;
      w_act_duty_nxt   = load ? duty_i   : r_pend_duty;
      w_act_mode_nxt   = load ? mode_i   : r_pend_mode;
      w_pend_nxt       = 1'b0;
      w_dir_nxt        = DirUp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_dir         <= DirUp;
      r_act_period  <= '1;
      r_act_duty    <= '0;
      r_act_mode    <= 1'b0;
      r_pend_period <= '0;
      r_pend_duty   <= '0;
      r_pend_mode   <= 1'b0;
      r_pend        <= 1'b0;
      r_pwm         <= '0;
      r_cyc         <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_dir         <= w_dir_nxt;
      r_act_period  <= w_act_period_nxt;
      r_act_duty    <= w_act_duty_nxt;
      r_act_mode    <= w_act_mode_nxt;
      r_pend_period <= w_pend_period_nxt;
      r_pend_duty   <= w_pend_duty_nxt;
      r_pend_mode   <= w_pend_mode_nxt;
      r_pend        <= w_pend_nxt;
      r_pwm         <= w_pwm_nxt;
      r_cyc         <= w_cyc_nxt;
    end
  end

  assign pwm_o  = r_pwm;
  assign cyc_o  = r_cyc;
  assign pend_o = r_pend;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a phase-index reference model predicts each cycle's
// outputs into a queue, and an independent monitor compares them against the DUT.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            load = 1'b0;
  logic [W-1:0]    period_i = '0;
  logic [CH*W-1:0] duty_i = '0;
  logic            mode_i = 1'b0;
  logic [CH-1:0]   pwm_o;
  logic            cyc_o;
  logic            pend_o;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .period_i(period_i),
    .duty_i  (duty_i),
    .mode_i  (mode_i),
    .pwm_o   (pwm_o),
    .cyc_o   (cyc_o),
    .pend_o  (pend_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          cyc;
    logic          pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: the period is a sequence of phases 0..L-1; cnt is derived from phase.
  int m_per, m_mode, m_duty[CH];
  int p_per, p_mode, p_duty[CH];
  bit m_pf;
  int m_p;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_per = 255; m_mode = 0; p_per = 0; p_mode = 0; m_pf = 0; m_p = 0;
    for (int k = 0; k < CH; k++) begin
      m_duty[k] = 0;
      p_duty[k] = 0;
    end
  endfunction

  function automatic int m_len();
    if (m_mode == 0) return m_per + 1;
    return (m_per == 0) ? 1 : 2 * m_per;
  endfunction

  function automatic int m_cnt();
    if (m_mode == 0 || m_p <= m_per) return m_p;
    return 2 * m_per - m_p;
  endfunction

  // Applies inputs for one cycle, updates the model and queues the post-edge expectation.
  task automatic cycle(input bit e, input bit ld, input int per, input logic [CH*W-1:0] dv,
                       input bit md);
    exp_t x;
    bit   wrap;
    bit   apply;
    int   c;
    @(negedge clk);
    rst = 1'b0; en = e; load = ld; period_i = W'(per); duty_i = dv; mode_i = md;
    c    = m_cnt();
    wrap = e && (m_p == m_len() - 1);
    for (int k = 0; k < CH; k++) x.pwm[k] = e && (c < m_duty[k]);
    x.cyc = wrap;
    apply = (!e || wrap) && (m_pf || ld);
    if (ld) begin
      p_per = per; p_mode = md;
      for (int k = 0; k < CH; k++) p_duty[k] = int'(dv[k*W +: W]);
    end
    m_p = (!e || wrap) ? 0 : m_p + 1;
    if (apply) begin
      m_per = p_per; m_mode = p_mode; m_pf = 0;
      for (int k = 0; k < CH; k++) m_duty[k] = p_duty[k];
    end else if (ld) begin
      m_pf = 1;
    end
    x.pend = m_pf;
    q.push_back(x);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic run_to_wrap_cycle(input int limit);
    int i = 0;
    while (m_p != m_len() - 1 && i < limit) begin
      cycle(1'b1, 1'b0, 0, '0, 1'b0);
      i++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pwm"}, 32'(pwm_o), 32'h0);
    chk({tag, "_cyc"}, 32'(cyc_o), 32'h0);
    chk({tag, "_pend"}, 32'(pend_o), 32'h0);
  endtask

  // Monitor: DUT outputs are presented every cycle; compare shortly after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pwm", 32'(pwm_o), 32'(e.pwm));
        chk("cyc", 32'(cyc_o), 32'(e.cyc));
        chk("pend", 32'(pend_o), 32'(e.pend));
      end
    end
  end

  initial begin
    logic [CH*W-1:0] dv;
    int per;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Four-channel edge-aligned setup loaded while idle.
    cycle(1'b0, 1'b1, 9, {8'd5, 8'd10, 8'd3, 8'd0}, 1'b0);
    run(34);

    // Mid-period duty change stays pending until the wrap.
    run_to_wrap_cycle(20);
    run(5);
    cycle(1'b1, 1'b1, 9, {8'd5, 8'd10, 8'd7, 8'd0}, 1'b0);
    run(25);

    // Load exactly in the wrap cycle, then two loads within one period.
    run_to_wrap_cycle(20);
    cycle(1'b1, 1'b1, 6, {8'd1, 8'd2, 8'd3, 8'd7}, 1'b0);
    run(2);
    cycle(1'b1, 1'b1, 5, {8'd4, 8'd4, 8'd4, 8'd4}, 1'b0);
    cycle(1'b1, 1'b1, 7, {8'd2, 8'd6, 8'd0, 8'd9}, 1'b0);
    run(20);

    // Center-aligned, period 4, duty 2.
    cycle(1'b1, 1'b1, 4, {4{8'd2}}, 1'b1);
    run(30);

    // Period 0, then asynchronous reset in the middle of a cycle.
    cycle(1'b0, 1'b1, 0, {4{8'd1}}, 1'b0);
    run(10);
    @(posedge clk);
    #3;
    rst = 1'b1; en = 1'b0; load = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    run(260);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 12));
      for (int k = 0; k < CH; k++) begin
        dv[k*W +: W] = W'($urandom_range(0, (per + 2 > 255) ? 255 : per + 2));
      end
      cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 11) == 0), per, dv,
            1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter WIDTH, default 8, counter/duty/period width in bits (>=2).
REQ-002 Parameter CHANNELS, default 4, number of PWM outputs sharing one counter (>=1).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  counter enable; low = idle.
REQ-006 load  input  1  one-cycle strobe; captures period_i, duty_i, mode_i into the pending set.
REQ-007 period_i  input  WIDTH  requested terminal count.
REQ-008 duty_i  input  CHANNELS*WIDTH  requested duty per channel; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 mode_i  input  1  requested mode: 0 edge-aligned, 1 center-aligned.
REQ-010 pwm_o  output  CHANNELS  registered PWM outputs.
REQ-011 cyc_o  output  1  registered one-cycle pulse marking period start.
REQ-012 pend_o  output  1  high while a captured set awaits application.

Function
REQ-013 The block SHALL hold an active set (period, duty per channel, mode) and a pending set plus a pending flag; only the active set drives counting and comparison.
REQ-014 load=1 SHALL copy period_i, duty_i, mode_i into the pending set and set the pending flag; a later load before application overwrites the pending set.
REQ-015 Edge mode: counter cnt SHALL increment by 1 each en cycle from 0 to active period, then return to 0; period length = period+1 cycles.
REQ-016 Center mode: cnt SHALL count up 0..period, then down period-1..1, then to 0; direction flag flips at cnt==period (to down) and at cnt==1 while down (to up); period length = 2*period cycles.
REQ-017 period==0 in either mode: cnt SHALL stay 0 and every en cycle SHALL be a wrap.
REQ-018 Wrap = en=1 cycle whose next cnt is 0 (edge: cnt==period; center: down and cnt==1, or cnt==period when period<=1).
REQ-019 At a wrap edge with pending flag set (or load=1 in that same cycle, which bypasses and applies its own inputs), the active set SHALL take the pending values, the flag SHALL clear, and the direction SHALL be set up.
REQ-020 While en=0: cnt held at 0, direction up, pwm_o all 0, cyc_o 0; pending set SHALL be applied to the active set on the next clock edge (no wrap wait).
REQ-021 pwm_o[k] SHALL be registered as (cnt < active duty[k]) with one-cycle latency from cnt; duty 0 gives constant 0, duty > period gives constant 1 (edge mode).
REQ-022 Comparison SHALL be unsigned, WIDTH bits; cnt SHALL never exceed active period and never underflow.
REQ-023 cyc_o SHALL be 1 for exactly the cycle after each wrap edge (cnt==0 that cycle) and 0 otherwise.
REQ-024 pend_o SHALL equal the pending flag register.
REQ-025 Mode change SHALL take effect only via the active set at a wrap (or while en=0), never mid-period.

Reset
REQ-026 On rst=1, asynchronously: cnt=0, direction up, active period = all ones, active duties = 0, active mode = 0, pending set = 0, pending flag = 0, pwm_o = 0, cyc_o = 0.
REQ-027 Reset mid-period SHALL discard pending and active sets; counting resumes from 0 on the first en cycle after rst deasserts.

Verification
REQ-028 WIDTH=8: rst, en=0, load period=9, duties {0,3,10,5}, mode 0; en=1 -> pwm_o[1] high 3 of every 10 cycles, [0] always 0, [2] always 1, cyc_o every 10 cycles.
REQ-029 Mode 1, period=4, duty=2 -> cnt 0,1,2,3,4,3,2,1,0..., pwm_o high 3 of every 8 cycles centered on cnt=0, cyc_o every 8.
REQ-030 Edge period=9 running; load duty=7 at cnt=4 -> pend_o=1, pwm_o width unchanged until wrap, then 7; pend_o clears at wrap.
REQ-031 load issued in the wrap cycle -> new values active for the immediately following period; two loads in one period -> only the second applied.
REQ-032 period=0, duty=1, en=1 -> cyc_o continuously 1 after first cycle, pwm_o constant 1; rst asserted mid-period -> all outputs 0 asynchronously, period reverts to 255.
